// File: rtl/oled_spi_arb.sv
// Shares one OLED SPI byte writer between the init sequencer (port 0) and the frame
// refresh reader (port 1). Optional macro OLED_ARB_RR_EN selects round-robin arbitration.
module oled_spi_arb #(
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_en,
  input  logic       req0_dc,
  input  logic [7:0] req0_data,
  output logic       req0_done,
  input  logic       req1_en,
  input  logic       req1_dc,
  input  logic [7:0] req1_data,
  output logic       req1_done,
  output logic       spi_ena,
  output logic       spi_dc,
  output logic [7:0] spi_data,
  input  logic       spi_done,
  output logic       owner,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  req_en;
  logic [1:0]  req_dc;
  logic [7:0]  req_data [2];
  logic [1:0]  pend;
  logic [1:0]  pend_dc;
  logic [7:0]  pend_data [2];
  logic [1:0]  pend_clr;
  logic [1:0]  pend_set;
  logic [15:0] wd_cnt;
  logic        wd_hit;
  logic        release_xfer;
  logic        grant_vld;
  logic        grant_port;

  assign req_en      = {req1_en, req0_en};
  assign req_dc      = {req1_dc, req0_dc};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  // Handshake: a requester pulses reqX_en for one cycle and must hold off until
  // reqX_done; the writer gets a one-cycle spi_ena and answers with spi_done.
  assign wd_hit       = (TIMEOUT != 16'd0) && (wd_cnt == TIMEOUT);
  assign release_xfer = (state == ST_WAIT) && (spi_done || wd_hit);
  assign grant_vld    = (state == ST_IDLE) && (pend != 2'b00);

`ifdef OLED_ARB_RR_EN
  logic last;

  // On a tie the port that was not granted last time wins.
  assign grant_port = (pend == 2'b11) ? ~last : ~pend[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last <= 1'b1;
    else if (grant_vld) last <= grant_port;
  end
`else
  assign grant_port = ~pend[0];
`endif

  // A new request landing in the same cycle as its own release is kept (set wins).
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pend_clr[i] = release_xfer && (owner == 1'(i));
      pend_set[i] = req_en[i] && (!pend[i] || pend_clr[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pend[i]      <= 1'b0;
        pend_dc[i]   <= 1'b0;
        pend_data[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pend_set[i]) begin
          pend[i]      <= 1'b1;
          pend_dc[i]   <= req_dc[i];
          pend_data[i] <= req_data[i];
        end else if (pend_clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (release_xfer) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    spi_ena   = (state == ST_ISSUE);
    busy      = (state != ST_IDLE);
    state_dbg = state;
  end

  // Grant datapath: write fields stay stable from ISSUE until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      spi_dc   <= 1'b1;
      spi_data <= 8'h00;
    end else if (grant_vld) begin
      owner    <= grant_port;
      spi_dc   <= pend_dc[grant_port];
      spi_data <= pend_data[grant_port];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
    end else begin
      req0_done <= pend_clr[0];
      req1_done <= pend_clr[1];
    end
  end

  // Watchdog counts WAIT cycles from zero and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= 16'd0;
    end else if (state == ST_ISSUE) begin
      wd_cnt <= 16'd0;
    end else if ((state == ST_WAIT) && (wd_cnt != 16'hFFFF)) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    timeout_err <= 1'b0;
    else if (release_xfer && !spi_done && wd_hit) timeout_err <= 1'b1;
  end

endmodule
